// File: rtl/axi_fpgaware_ver_id.sv
// -----------------------------------------------------------------------------
// axi_fpgaware_ver_id
// AXI4-Lite slave exposing one read-only version/ID word. Every read address
// returns ID, or i_external_value when i_set_external_value is high at the
// address handshake. Writes are acknowledged OKAY and discarded.
// s_axi_aresetn is a synchronous, active-high reset despite its name.
// -----------------------------------------------------------------------------
module axi_fpgaware_ver_id #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    WSTRB_WIDTH = DATA_WIDTH / 8,
   parameter logic [DATA_WIDTH-1:0] ID          = 32'h00000001
) (
   input  logic                   s_axi_aclk,
   input  logic                   s_axi_aresetn,
   // write address channel
   input  logic                   s_axi_awvalid,
   input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
   output logic                   s_axi_awready,
   // write data channel
   input  logic                   s_axi_wvalid,
   input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
   input  logic [WSTRB_WIDTH-1:0] s_axi_wstrb,
   output logic                   s_axi_wready,
   // write response channel
   output logic                   s_axi_bvalid,
   output logic [1:0]             s_axi_bresp,
   input  logic                   s_axi_bready,
   // read address channel
   input  logic                   s_axi_arvalid,
   input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
   output logic                   s_axi_arready,
   // read data channel
   output logic                   s_axi_rvalid,
   output logic [DATA_WIDTH-1:0]  s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   input  logic                   s_axi_rready,
   // ID source select
   input  logic                   i_set_external_value,
   input  logic [DATA_WIDTH-1:0]  i_external_value
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ACK,  W_RESP} wr_state_t;

   rd_state_t             r_rd_state;
   rd_state_t             w_rd_next;
   wr_state_t             r_wr_state;
   wr_state_t             w_wr_next;

   logic                  r_arready;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_bvalid;

   logic [DATA_WIDTH-1:0] w_rd_word;

   // Addresses, write data and strobes carry no meaning for a single ID word.
   logic                  w_unused_inputs;
   assign w_unused_inputs = &{1'b0, s_axi_awaddr, s_axi_wdata, s_axi_wstrb, s_axi_araddr};

   // Word returned by the next read, captured only at the address handshake.
   assign w_rd_word = i_set_external_value ? i_external_value : ID;

   // Read next-state: idle -> one-cycle arready -> hold rvalid until rready.
   always_comb begin
      // NOTE: default assigned first so every path drives w_rd_next; no latch.
      w_rd_next = r_rd_state;
      case (r_rd_state)
         R_IDLE:  if (s_axi_arvalid) w_rd_next = R_ADDR;
         R_ADDR:  w_rd_next = R_DATA;
         R_DATA:  if (s_axi_rready)  w_rd_next = R_IDLE;
         default: w_rd_next = R_IDLE;
      endcase
   end

   // Read state register and registered read-channel outputs.
   always_ff @(posedge s_axi_aclk) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      if (s_axi_aresetn) begin
         r_rd_state <= R_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_rd_state <= w_rd_next;
         r_arready  <= (w_rd_next == R_ADDR);
         r_rvalid   <= (w_rd_next == R_DATA);
         if (r_rd_state == R_ADDR) r_rdata <= w_rd_word;
      end
   end

   // Write next-state: wait for address+data, ack both, hold bvalid until bready.
   always_comb begin
      w_wr_next = r_wr_state;
      case (r_wr_state)
         W_IDLE:  if (s_axi_awvalid && s_axi_wvalid) w_wr_next = W_ACK;
         W_ACK:   w_wr_next = W_RESP;
         W_RESP:  if (s_axi_bready) w_wr_next = W_IDLE;
         default: w_wr_next = W_IDLE;
      endcase
   end

   // Write state register and registered write-channel outputs.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_aresetn) begin
         r_wr_state <= W_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
      end else begin
         r_wr_state <= w_wr_next;
         r_awready  <= (w_wr_next == W_ACK);
         r_wready   <= (w_wr_next == W_ACK);
         r_bvalid   <= (w_wr_next == W_RESP);
      end
   end

   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = 2'b00;
   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = 2'b00;

endmodule

// File: tb/tb_axi_fpgaware_ver_id.sv
// -----------------------------------------------------------------------------
// tb_axi_fpgaware_ver_id
// Self-checking bench: expected read words are pushed to a scoreboard queue
// when a read is issued and popped when rvalid is observed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_fpgaware_ver_id;

   localparam logic [31:0] TB_ID  = 32'h01234567;
   localparam logic [31:0] EXT_ID = 32'h89ABCDEF;
   localparam int          BOUND  = 10;

   logic        clk;
   logic        rst;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] awaddr, wdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] araddr, rdata;
   logic        sel;
   logic [31:0] ext;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb_q[$];

   axi_fpgaware_ver_id #(.ID(TB_ID)) dut (
      .s_axi_aclk           (clk),
      .s_axi_aresetn        (rst),
      .s_axi_awvalid        (awvalid),
      .s_axi_awaddr         (awaddr),
      .s_axi_awready        (awready),
      .s_axi_wvalid         (wvalid),
      .s_axi_wdata          (wdata),
      .s_axi_wstrb          (wstrb),
      .s_axi_wready         (wready),
      .s_axi_bvalid         (bvalid),
      .s_axi_bresp          (bresp),
      .s_axi_bready         (bready),
      .s_axi_arvalid        (arvalid),
      .s_axi_araddr         (araddr),
      .s_axi_arready        (arready),
      .s_axi_rvalid         (rvalid),
      .s_axi_rdata          (rdata),
      .s_axi_rresp          (rresp),
      .s_axi_rready         (rready),
      .i_set_external_value (sel),
      .i_external_value     (ext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one read; hold >0 keeps rready low for that many cycles first.
   task automatic do_read(input string tag, input logic s, input logic [31:0] addr,
                          input int hold, input bit rready_pre, input bit toggle_sel);
      int n;
      logic [31:0] exp;
      sel     = s;
      araddr  = addr;
      rready  = rready_pre;
      sb_q.push_back(s ? ext : TB_ID);
      arvalid = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!arready && n < BOUND);
      check({tag, "_ar_latency"}, n, 1);
      tick();
      arvalid = 1'b0;
      if (toggle_sel) sel = ~s;
      check({tag, "_ar_pulse"}, {31'b0, arready}, 0);
      check({tag, "_rvalid_rise"}, {31'b0, rvalid}, 1);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
      check({tag, "_rdata"}, rdata, exp);
      check({tag, "_rresp"}, {30'b0, rresp}, 0);
      if (!rready_pre) begin
         for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_rvalid_hold"}, {31'b0, rvalid}, 1);
            check({tag, "_rdata_hold"}, rdata, exp);
         end
         rready = 1'b1;
      end
      tick();
      rready = 1'b0;
      sel    = s;
      check({tag, "_rvalid_drop"}, {31'b0, rvalid}, 0);
   endtask

   task automatic do_write(input string tag, input logic [31:0] d, input int hold);
      int n;
      awaddr  = 32'h0000_0010;
      wdata   = d;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!awready && n < BOUND);
      check({tag, "_aw_latency"}, n, 1);
      check({tag, "_wready_with_aw"}, {31'b0, wready}, 1);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check({tag, "_awready_pulse"}, {31'b0, awready}, 0);
      check({tag, "_wready_pulse"}, {31'b0, wready}, 0);
      check({tag, "_bvalid_rise"}, {31'b0, bvalid}, 1);
      check({tag, "_bresp"}, {30'b0, bresp}, 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_bvalid_hold"}, {31'b0, bvalid}, 1);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check({tag, "_bvalid_drop"}, {31'b0, bvalid}, 0);
   endtask

   initial begin
      rst = 1'b1;
      awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
      arvalid = 0; araddr = 0; rready = 0; sel = 0; ext = EXT_ID;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("rst_arready", {31'b0, arready}, 0);
      check("rst_rvalid",  {31'b0, rvalid}, 0);
      check("rst_awready", {31'b0, awready}, 0);
      check("rst_wready",  {31'b0, wready}, 0);
      check("rst_bvalid",  {31'b0, bvalid}, 0);
      check("rst_rdata",   rdata, 0);
      rst = 1'b0;
      tick();
      check("idle_arready_low", {31'b0, arready}, 0);

      // Basic read with rvalid held until rready
      do_read("basic", 1'b0, 32'h7000_0000, 4, 1'b0, 1'b0);
      // rready pre-asserted: rvalid lasts one cycle
      do_read("rready_pre", 1'b0, 32'h7000_0000, 0, 1'b1, 1'b0);
      // External select, two consecutive reads
      do_read("ext0", 1'b1, 32'h0000_0004, 1, 1'b0, 1'b0);
      do_read("ext1", 1'b1, 32'hFFFF_FFFC, 0, 1'b1, 1'b0);
      // Select changes after the handshake must not affect pending data
      do_read("toggle_id", 1'b0, 32'h1234_5678, 3, 1'b0, 1'b1);
      do_read("toggle_ext", 1'b1, 32'h0000_0000, 3, 1'b0, 1'b1);

      // Write is acknowledged and discarded
      do_write("write", 32'hDEAD_BEEF, 3);
      do_read("after_write", 1'b0, 32'h0000_0000, 1, 1'b0, 1'b0);

      // Reset during R_DATA aborts the read
      sel = 1'b1;
      arvalid = 1'b1;
      tick();
      tick();
      arvalid = 1'b0;
      check("abort_rvalid_before", {31'b0, rvalid}, 1);
      rst = 1'b1;
      tick();
      check("abort_rvalid", {31'b0, rvalid}, 0);
      check("abort_rdata", rdata, 0);
      rst = 1'b0;
      sel = 1'b0;
      tick();
      check("abort_idle", {31'b0, rvalid | arready}, 0);
      do_read("post_abort", 1'b0, 32'h0000_0008, 1, 1'b0, 1'b0);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
